s_axis_kernel_collector: RTL and testbench
==========================================

S_AXIS_KERNEL_COLLECTOR -- requirements
Module: s_axis_kernel_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the pixel width in bits.
REQ-002 Parameter IMAGE_KERNEL_12K, default 64, is the number of pixels per kernel; IMG_WIDTH SHALL be an integer multiple of it.
REQ-003 Parameter IMG_WIDTH, default 4096, is the number of pixels per line.
REQ-004 Parameter IMG_HEIGHT, default 3072, is the number of lines per frame.
REQ-005 i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 i_reset  in  1  reset, synchronous and active-high.
REQ-007 s_axis_tdata  in  DATA_WIDTH  input pixel.
REQ-008 s_axis_tvalid  in  1  input beat valid.
REQ-009 s_axis_tready  out  1  beat accepted when tvalid&tready are both high.
REQ-010 s_axis_tuser  in  1  start of frame (first pixel of line 0).
REQ-011 s_axis_tlast  in  1  end of line (pixel IMG_WIDTH-1).
REQ-012 o_image_kernel  out  [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]  assembled kernel; index 0 is the first-received pixel.
REQ-013 o_kernel_valid  out  1  o_image_kernel holds a complete, untaken kernel.
REQ-014 i_kernel_taken  in  1  consumer takes the kernel on a cycle where it and o_kernel_valid are both high.
REQ-015 o_frame_start  out  1  qualified by o_kernel_valid; kernel index 0 is the frame's first pixel.
REQ-016 o_err_sof  out  1  one-cycle pulse: tuser on an accepted beat that is not pixel 0 of line 0.
REQ-017 o_err_eol  out  1  one-cycle pulse: tlast on an accepted beat disagrees with the expected pixel position (IMG_WIDTH-1).

Function
REQ-018 States SHALL be IDLE, COLLECT and STALL.
REQ-019 IDLE: s_axis_tready=1; beats without tuser are dropped; an accepted beat with tuser is stored at fill index 0, sets the frame_start flag, moves to COLLECT.
REQ-020 COLLECT: s_axis_tready=1; each accepted beat is written at the fill index, which increments and wraps from IMAGE_KERNEL_12K-1 to 0.
REQ-021 On the accepted beat at fill index IMAGE_KERNEL_12K-1: if the output is empty or i_kernel_taken is high this cycle, the fill buffer plus this pixel loads o_image_kernel and o_kernel_valid=1 on the next cycle, with no gap; otherwise the state moves to STALL.
REQ-022 STALL: s_axis_tready=0; when the output is freed by i_kernel_taken, the fill buffer loads the output on the next cycle and the state moves to COLLECT; if the stalled kernel closed the frame, the state moves to IDLE instead.
REQ-023 s_axis_tready SHALL be a function of the registered state only, with no combinational path from any input.
REQ-024 o_kernel_valid SHALL stay high, with o_image_kernel and o_frame_start stable, until taken; it deasserts on the cycle after the take unless a new kernel loads on that same edge.
REQ-025 Pixel counter (0..IMG_WIDTH-1) and line counter (0..IMG_HEIGHT-1) SHALL advance on accepted beats in COLLECT and wrap; widths are $clog2 of their ranges.
REQ-026 After the accepted beat at pixel IMG_WIDTH-1 of line IMG_HEIGHT-1, the state SHALL go to IDLE, or to STALL and then IDLE.
REQ-027 tuser mid-frame in COLLECT SHALL pulse o_err_sof, discard the partial kernel, reset the counters, and store the beat as fill index 0 of a new frame.
REQ-028 A tlast mismatch SHALL pulse o_err_eol only; the counters keep counting by position.
REQ-029 Latency SHALL be one cycle from acceptance of the last kernel beat to o_kernel_valid, when the output is free.

Reset
REQ-030 On i_reset the state SHALL be IDLE, fill index and counters 0, and o_image_kernel all 0.
REQ-031 During and on the cycle after reset, o_kernel_valid, o_frame_start, o_err_sof, o_err_eol and s_axis_tready SHALL be 0.
REQ-032 Reset mid-frame SHALL discard all partial and held kernels.

Structure
REQ-033 The state typedef and the shared defaults of DATA_WIDTH, IMAGE_KERNEL_12K, IMG_WIDTH and IMG_HEIGHT SHALL live in package remapper_pkg, shared with the stream transmitter.
REQ-034 The pixel/line counters and the tuser/tlast checks SHALL be one sub-module, s_axis_frame_tracker; buffers and the FSM stay in the top.

Verification
REQ-035 Reset, then one frame of data = pixel index mod 256 with i_kernel_taken tied high -> the first kernel is 0..63 with o_frame_start=1, every following kernel has o_frame_start=0, tready is never low, and there are no error pulses.
REQ-036 i_kernel_taken held low after the first kernel -> the second kernel fills, tready drops the cycle after beat 127; raising taken -> the second kernel is valid the next cycle and tready returns.
REQ-037 Beats without tuser in IDLE -> all dropped with tready=1, and no kernel is produced.
REQ-038 tuser at pixel 100 of line 5 -> o_err_sof pulses once, and the next kernel starts with that pixel with o_frame_start=1.
REQ-039 tlast at pixel 4094 -> o_err_eol pulses once; tlast absent at pixel 4095 -> o_err_eol pulses once; the line count is unaffected.
REQ-040 i_reset asserted at pixel 30 of a kernel -> o_kernel_valid=0, the state returns to IDLE, and the partial data never appears on the output.

Source files
------------

// File: rtl/remapper_pkg.sv
// Shared types and default geometry for the kernel collector and stream transmitter.
package remapper_pkg;

  localparam int unsigned DATA_WIDTH_DEF       = 8;
  localparam int unsigned IMAGE_KERNEL_12K_DEF = 64;
  localparam int unsigned IMG_WIDTH_DEF        = 4096;
  localparam int unsigned IMG_HEIGHT_DEF       = 3072;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STALL   = 2'd2
  } collector_state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s_axis_frame_tracker.sv
// Tracks pixel/line position of in-frame beats and flags tuser/tlast misplacement.
module s_axis_frame_tracker
  import remapper_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_i,        // accepted beat that belongs to a frame
  input  logic tuser_i,
  input  logic tlast_i,
  output logic frame_end_c_o, // this beat is the last pixel of the frame
  output logic err_sof_o,
  output logic err_eol_o
);

  localparam int unsigned PIX_W  = cnt_width(IMG_WIDTH);
  localparam int unsigned LINE_W = cnt_width(IMG_HEIGHT);

  logic [PIX_W-1:0]  pix_q, pix_cur, pix_d;
  logic [LINE_W-1:0] line_q, line_cur, line_d;
  logic              restart, at_eol, at_eof;
  logic              err_sof_q, err_eol_q;

  // Position of the current beat (a tuser beat is pixel 0 of line 0) and its successor.
  always_comb begin
    restart       = beat_i & tuser_i;
    pix_cur       = restart ? '0 : pix_q;
    line_cur      = restart ? '0 : line_q;
    at_eol        = (pix_cur == PIX_W'(IMG_WIDTH - 1));
    at_eof        = at_eol && (line_cur == LINE_W'(IMG_HEIGHT - 1));
    pix_d         = at_eol ? '0 : pix_cur + PIX_W'(1);
    line_d        = at_eol ? (at_eof ? '0 : line_cur + LINE_W'(1)) : line_cur;
    frame_end_c_o = beat_i & at_eof;
  end

  // Counters advance by position only; error flags are single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q     <= '0;
      line_q    <= '0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
    end else begin
      err_sof_q <= restart & ((pix_q != '0) | (line_q != '0));
      err_eol_q <= beat_i & (tlast_i != at_eol);
      if (beat_i) begin
        pix_q  <= pix_d;
        line_q <= line_d;
      end
    end
  end

  assign err_sof_o = err_sof_q;
  assign err_eol_o = err_eol_q;

endmodule

// File: rtl/s_axis_kernel_collector.sv
// Collects AXI-Stream pixels into fixed-size kernels with a one-deep output hold.
module s_axis_kernel_collector
  import remapper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned IMAGE_KERNEL_12K = IMAGE_KERNEL_12K_DEF,
  parameter int unsigned IMG_WIDTH        = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT       = IMG_HEIGHT_DEF
) (
  input  logic                                              i_clk,
  input  logic                                              i_reset,
  input  logic [DATA_WIDTH-1:0]                             s_axis_tdata,
  input  logic                                              s_axis_tvalid,
  output logic                                              s_axis_tready,
  input  logic                                              s_axis_tuser,
  input  logic                                              s_axis_tlast,
  output logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]       o_image_kernel,
  output logic                                              o_kernel_valid,
  input  logic                                              i_kernel_taken,
  output logic                                              o_frame_start,
  output logic                                              o_err_sof,
  output logic                                              o_err_eol
);

  localparam int unsigned IDX_W = cnt_width(IMAGE_KERNEL_12K);

  collector_state_e                            state_q;
  logic [IDX_W-1:0]                            fill_idx_q, widx_c;
  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] fill_q, fill_d, kernel_q;
  logic fill_fs_q, fs_q, valid_q, tready_q, stall_eof_q;
  logic accept_c, in_frame_c, restart_c, complete_c, out_free_c, fill_fs_c, frame_end_c;

  // Beat classification: IDLE only admits a tuser beat, COLLECT admits everything.
  always_comb begin
    accept_c   = s_axis_tvalid & tready_q;
    in_frame_c = accept_c & (((state_q == ST_IDLE) & s_axis_tuser) | (state_q == ST_COLLECT));
    restart_c  = in_frame_c & s_axis_tuser;
    widx_c     = restart_c ? '0 : fill_idx_q;
    complete_c = in_frame_c & (widx_c == IDX_W'(IMAGE_KERNEL_12K - 1));
    out_free_c = ~valid_q | i_kernel_taken;
    fill_fs_c  = restart_c | fill_fs_q;
  end

  // Fill buffer with the current beat merged in, so completion can bypass straight to the output.
  always_comb begin
    fill_d         = fill_q;
    fill_d[widx_c] = s_axis_tdata;
  end

  s_axis_frame_tracker #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_tracker (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .beat_i       (in_frame_c),
    .tuser_i      (s_axis_tuser),
    .tlast_i      (s_axis_tlast),
    .frame_end_c_o(frame_end_c),
    .err_sof_o    (o_err_sof),
    .err_eol_o    (o_err_eol)
  );

  // Fill buffer storage; contents are only meaningful up to the fill index.
  always_ff @(posedge i_clk) begin
    if (in_frame_c) fill_q <= fill_d;
  end

  // Control FSM plus output hold register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      fill_idx_q  <= '0;
      fill_fs_q   <= 1'b0;
      kernel_q    <= '0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      tready_q    <= 1'b0;
      stall_eof_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (valid_q && i_kernel_taken) valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (in_frame_c) begin
            fill_fs_q <= fill_fs_c;
            if (complete_c) begin
              fill_idx_q <= '0;
              if (out_free_c) begin
                kernel_q  <= fill_d;
                valid_q   <= 1'b1;
                fs_q      <= fill_fs_c;
                fill_fs_q <= 1'b0;
                state_q   <= frame_end_c ? ST_IDLE : ST_COLLECT;
              end else begin
                state_q     <= ST_STALL;
                stall_eof_q <= frame_end_c;
                tready_q    <= 1'b0;
              end
            end else begin
              fill_idx_q <= widx_c + IDX_W'(1);
              state_q    <= ST_COLLECT;
            end
          end
        end
        ST_STALL: begin
          if (valid_q && i_kernel_taken) begin
            kernel_q  <= fill_q;
            valid_q   <= 1'b1;
            fs_q      <= fill_fs_q;
            fill_fs_q <= 1'b0;
            state_q   <= stall_eof_q ? ST_IDLE : ST_COLLECT;
          end else begin
            tready_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready  = tready_q;
  assign o_image_kernel = kernel_q;
  assign o_kernel_valid = valid_q;
  assign o_frame_start  = fs_q;

endmodule

// File: tb/tb_s_axis_kernel_collector.sv
// Self-checking bench: stream-level reference model plus directed scenarios.
module tb_s_axis_kernel_collector;

  localparam int unsigned DW = 8;
  localparam int unsigned K  = 64;
  localparam int unsigned W  = 4096;
  localparam int unsigned H  = 6;

  typedef logic [0:K-1][DW-1:0] kern_t;
  typedef struct {
    kern_t  k;
    bit     fs;
    longint cyc;
  } kexp_t;

  logic          clk, i_reset;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tuser, tlast, taken;
  kern_t         o_image_kernel;
  logic          o_kernel_valid, o_frame_start, o_err_sof, o_err_eol;

  s_axis_kernel_collector #(
    .DATA_WIDTH(DW), .IMAGE_KERNEL_12K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .o_image_kernel(o_image_kernel), .o_kernel_valid(o_kernel_valid),
    .i_kernel_taken(taken), .o_frame_start(o_frame_start),
    .o_err_sof(o_err_sof), .o_err_eol(o_err_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model state
  kexp_t     q[$];
  logic [DW-1:0] mbuf[$];
  kern_t     tk_log[$];
  bit        tk_fs[$];
  bit        m_in = 0, m_fs = 0, sof_pend = 0, eol_pend = 0, rst_prev = 1, armed = 0;
  int        m_pix = 0, m_line = 0;
  longint    cyc = 0;
  int        n_valid_cyc = 0, n_takes = 0, n_sof = 0, n_eol = 0, n_rdy_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_k(input string name, input logic [K*DW-1:0] act, input logic [K*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic kern_t logged(input int i);
    if (i < tk_log.size()) return tk_log[i];
    return '1;
  endfunction

  // Stream-level model: kernels are groups of K in-frame pixels, one held at the output.
  task automatic monitor();
    kexp_t e;
    bit    exp_valid, exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        exp_valid = (q.size() > 0) && (q[0].cyc < cyc);
        exp_rdy   = !rst_prev && (q.size() < 2);
        chk("kernel_valid", o_kernel_valid, exp_valid);
        chk("tready", tready, exp_rdy);
        chk("err_sof", o_err_sof, sof_pend);
        chk("err_eol", o_err_eol, eol_pend);
        if (o_kernel_valid === 1'b1) n_valid_cyc++;
        if (o_err_sof === 1'b1) n_sof++;
        if (o_err_eol === 1'b1) n_eol++;
        if (!rst_prev && tready !== 1'b1) n_rdy_low++;
        if (o_kernel_valid === 1'b1 && q.size() > 0) begin
          chk_k("kernel_data", o_image_kernel, q[0].k);
          chk("frame_start", o_frame_start, q[0].fs);
          if (taken) begin
            tk_log.push_back(o_image_kernel);
            tk_fs.push_back(o_frame_start);
            n_takes++;
            void'(q.pop_front());
          end
        end
      end
      sof_pend = 0;
      eol_pend = 0;
      if (i_reset) begin
        q.delete(); mbuf.delete();
        m_in = 0; m_fs = 0; m_pix = 0; m_line = 0;
        armed = 1;
      end else if (armed && tvalid && tready === 1'b1 && (m_in || tuser)) begin
        if (tuser) begin
          sof_pend = m_in && (m_pix != 0 || m_line != 0);
          m_in = 1; m_pix = 0; m_line = 0; m_fs = 1;
          mbuf.delete();
        end
        eol_pend = (tlast != (m_pix == W - 1));
        mbuf.push_back(tdata);
        if (mbuf.size() == K) begin
          for (int i = 0; i < K; i++) e.k[i] = mbuf[i];
          e.fs = m_fs; e.cyc = cyc;
          q.push_back(e);
          m_fs = 0;
          mbuf.delete();
        end
        if (m_pix == W - 1) begin
          m_pix = 0;
          if (m_line == H - 1) begin m_line = 0; m_in = 0; end
          else m_line++;
        end else m_pix++;
      end
      rst_prev = i_reset;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, output bit ok);
    bit acc;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      acc = (tready === 1'b1);
      @(posedge clk); #1;
      ok = acc;
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Beats carry data = global index mod 256; tlast sits at W-2 instead of W-1 on bad_line.
  task automatic stream(input int first, input int cnt, input int sof_a, input int sof_b, input int bad_line);
    bit ok;
    int pix, line;
    ok = 1;
    for (int p = first; p < first + cnt && ok; p++) begin
      pix  = p % W;
      line = p / W;
      send_beat(DW'(p), (p == sof_a) || (p == sof_b),
                (line == bad_line) ? (pix == W - 2) : (pix == W - 1), ok);
    end
    chk("stream_accept", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_kernel_valid, 0);
    chk("rst_fs", o_frame_start, 0);
    chk("rst_err_sof", o_err_sof, 0);
    chk("rst_err_eol", o_err_eol, 0);
    chk("rst_tready", tready, 0);
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", o_kernel_valid, 0);
    chk("post_rst_tready", tready, 0);
    chk_k("post_rst_kernel", o_image_kernel, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_tk, b_sof, b_eol, b_rdy, b_val;
    kern_t tmp;
    i_reset = 1'b1; tvalid = 0; tdata = '0; tuser = 0; tlast = 0; taken = 1'b1;
    fork monitor(); join_none

    // Reset state
    do_reset();

    // One frame, consumer always ready
    b_tk = n_takes; b_sof = n_sof; b_eol = n_eol; b_rdy = n_rdy_low;
    stream(0, W * H, 0, -1, -1);
    repeat (4) @(posedge clk); #1;
    chk("f1_kernels", n_takes - b_tk, (W * H) / K);
    chk("f1_tready_low", n_rdy_low - b_rdy, 0);
    chk("f1_err_sof", n_sof - b_sof, 0);
    chk("f1_err_eol", n_eol - b_eol, 0);
    tmp = logged(b_tk);     chk("f1_k0_first", tmp[0], 0); chk("f1_k0_last", tmp[K-1], 63);
    chk("f1_k0_fs", tk_fs[b_tk], 1);
    tmp = logged(b_tk + 1); chk("f1_k1_first", tmp[0], 64);
    chk("f1_k1_fs", tk_fs[b_tk + 1], 0);
    tmp = logged(b_tk + 4); chk("f1_k4_first", tmp[0], 0);

    // Back-pressure: second kernel stalls until the first is taken
    taken = 1'b0;
    stream(0, 128, 0, -1, -1);
    @(negedge clk);
    chk("stall_tready", tready, 0);
    chk("stall_valid", o_kernel_valid, 1);
    tmp = o_image_kernel; chk("stall_k_first", tmp[0], 0);
    repeat (3) @(negedge clk);
    chk("stall_tready_held", tready, 0);
    @(posedge clk); #1 taken = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("unstall_tready", tready, 1);
    chk("unstall_valid", o_kernel_valid, 1);
    tmp = o_image_kernel;
    chk("unstall_k_first", tmp[0], 64); chk("unstall_k_last", tmp[K-1], 127);
    chk("unstall_fs", o_frame_start, 0);
    @(posedge clk); #1;

    // Reset 30 pixels into a kernel, then tuser-less beats in IDLE
    stream(128, K + 30, -1, -1, -1);
    do_reset();
    b_val = n_valid_cyc; b_tk = n_takes; b_rdy = n_rdy_low;
    stream(0, 200, -1, -1, -1);
    repeat (4) @(posedge clk); #1;
    chk("idle_valid_cycles", n_valid_cyc - b_val, 0);
    chk("idle_kernels", n_takes - b_tk, 0);
    chk("idle_tready_low", n_rdy_low - b_rdy, 0);
    chk_k("idle_kernel_zero", o_image_kernel, '0);

    // tuser at pixel 100 of line 5
    do_reset();
    b_tk = n_takes; b_sof = n_sof; b_eol = n_eol;
    stream(0, 5 * W + 100 + K, 0, 5 * W + 100, -1);
    repeat (4) @(posedge clk); #1;
    chk("sof_pulses", n_sof - b_sof, 1);
    chk("sof_eol_pulses", n_eol - b_eol, 0);
    chk("sof_kernels", n_takes - b_tk, 322);
    tmp = logged(b_tk + 321);
    chk("sof_k_first", tmp[0], 100); chk("sof_k_last", tmp[K-1], 163);
    chk("sof_k_fs", tk_fs[b_tk + 321], 1);

    // tlast at W-2 and missing at W-1 on line 0; frame still ends at W*H
    do_reset();
    b_tk = n_takes; b_sof = n_sof; b_eol = n_eol; b_val = n_valid_cyc;
    stream(0, W * H, 0, -1, 0);
    repeat (4) @(posedge clk); #1;
    chk("eol_pulses", n_eol - b_eol, 2);
    chk("eol_kernels", n_takes - b_tk, (W * H) / K);
    chk("eol_sof_pulses", n_sof - b_sof, 0);
    b_val = n_valid_cyc;
    stream(W * H, 100, -1, -1, -1);
    repeat (4) @(posedge clk); #1;
    chk("eol_after_frame_valid", n_valid_cyc - b_val, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
